// File: rtl/spi_cmd_responder.sv
// Mode-3 SPI slave oversampled in the sys_clk domain: status byte out during the
// command byte, then RX delivery or TX FIFO streaming for the read command.
//
// state | meaning
// IDLE  | NSS high or frame not yet started; waiting for NSS fall
// CMD   | shifting the command byte, status byte goes out on MISO
// DATA  | data phase; bytes to rx_data, MISO from FIFO or dummy
module spi_cmd_responder #(
  parameter logic [7:0] READ_CMD    = 8'h01,
  parameter logic [7:0] DUMMY_BYTE  = 8'h00,
  parameter int         CNT_W       = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_nrst,
  input  logic             SCK,
  input  logic             NSS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [7:0]       status,
  output logic [7:0]       cmd,
  output logic             cmd_valid,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic [7:0]       tx_data,
  input  logic             tx_empty,
  output logic             tx_rd_en,
  output logic [CNT_W-1:0] byte_count,
  output logic             frame_end,
  output logic             frame_err,
  output logic             tx_underrun
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES:0]   sck_q;
  logic [SYNC_STAGES:0]   nss_q;
  logic [SYNC_STAGES-1:0] mosi_q;

  logic [7:0]       tx_shift_q, rx_shift_q, cmd_q, rx_data_q;
  logic [2:0]       bit_cnt_q;
  logic [CNT_W-1:0] byte_count_q;
  logic             miso_q, cmd_valid_q, rx_valid_q, tx_rd_en_q;
  logic             frame_end_q, frame_err_q, tx_underrun_q;

  logic       sck_rise, sck_fall, nss_rise, nss_fall, mosi_s;
  logic [7:0] rx_byte, done_cmd;

  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_q[SYNC_STAGES];
  assign nss_rise = nss_q[SYNC_STAGES-1] & ~nss_q[SYNC_STAGES];
  assign nss_fall = ~nss_q[SYNC_STAGES-1] & nss_q[SYNC_STAGES];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign rx_byte  = {rx_shift_q[6:0], mosi_s};
  assign done_cmd = (state_q == CMD) ? rx_byte : cmd_q;

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (nss_fall) state_d = CMD;
      CMD: begin
        if (nss_rise)                          state_d = IDLE;
        else if (sck_rise && bit_cnt_q == 3'd7) state_d = DATA;
      end
      DATA:    if (nss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NSS chain resets low so a frame in progress at reset release is not
  // mistaken for a new one; only a fresh NSS fall starts a frame.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      sck_q         <= '1;
      nss_q         <= '0;
      mosi_q        <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      cmd_q         <= '0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      byte_count_q  <= '0;
      miso_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_rd_en_q    <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sck_q       <= {sck_q[SYNC_STAGES-1:0], SCK};
      nss_q       <= {nss_q[SYNC_STAGES-1:0], NSS};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      cmd_valid_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_rd_en_q  <= 1'b0;
      frame_end_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q == IDLE) begin
        if (nss_fall) begin
          tx_shift_q    <= status;
          bit_cnt_q     <= '0;
          byte_count_q  <= '0;
          tx_underrun_q <= 1'b0;
        end
      end else if (nss_rise) begin
        frame_end_q <= 1'b1;
        frame_err_q <= (bit_cnt_q != 3'd0);
        miso_q      <= 1'b0;
      end else begin
        if (sck_fall) begin
          miso_q     <= tx_shift_q[7];
          tx_shift_q <= {tx_shift_q[6:0], 1'b0};
        end
        if (sck_rise) begin
          rx_shift_q <= rx_byte;
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == CMD) begin
              cmd_q       <= rx_byte;
              cmd_valid_q <= 1'b1;
            end else begin
              rx_data_q  <= rx_byte;
              rx_valid_q <= 1'b1;
              if (byte_count_q != '1) byte_count_q <= byte_count_q + 1'b1;
            end
            if (done_cmd == READ_CMD && !tx_empty) begin
              tx_shift_q <= tx_data;
              tx_rd_en_q <= 1'b1;
            end else begin
              tx_shift_q <= DUMMY_BYTE;
              if (done_cmd == READ_CMD) tx_underrun_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign MISO        = miso_q;
  assign cmd         = cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_rd_en    = tx_rd_en_q;
  assign byte_count  = byte_count_q;
  assign frame_end   = frame_end_q;
  assign frame_err   = frame_err_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_cmd_responder.sv
// Scoreboard bench for spi_cmd_responder: a bit-banged mode-3 master and a FIFO
// model drive the DUT; a monitor pops expected cmd/rx/frame/MISO values.
module tb_spi_cmd_responder;
  localparam int HALF = 80;

  logic        sys_clk = 1'b0;
  logic        sys_nrst = 1'b0;
  logic        SCK = 1'b1;
  logic        NSS = 1'b1;
  logic        MOSI = 1'b0;
  logic [7:0]  status = 8'h00;
  logic        MISO;
  logic [7:0]  cmd, rx_data, tx_data;
  logic        cmd_valid, rx_valid, tx_empty, tx_rd_en;
  logic [15:0] byte_count;
  logic        frame_end, frame_err, tx_underrun;

  logic [7:0] fifo_mem [0:63];
  logic [5:0] wr_ptr = 6'd0;
  logic [5:0] rd_ptr = 6'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0;

  logic [7:0]  exp_cmd[$], exp_rx[$], exp_miso[$], got_miso[$];
  logic [16:0] exp_frame[$];

  localparam logic [7:0] DIG [16] = '{8'ha9, 8'h99, 8'h3e, 8'h36, 8'h47, 8'h06, 8'h81, 8'h6a,
                                      8'hba, 8'h3e, 8'h25, 8'h71, 8'h78, 8'h50, 8'hc2, 8'h6c};

  spi_cmd_responder dut (
    .sys_clk(sys_clk), .sys_nrst(sys_nrst), .SCK(SCK), .NSS(NSS), .MOSI(MOSI),
    .MISO(MISO), .status(status), .cmd(cmd), .cmd_valid(cmd_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_empty(tx_empty),
    .tx_rd_en(tx_rd_en), .byte_count(byte_count), .frame_end(frame_end),
    .frame_err(frame_err), .tx_underrun(tx_underrun)
  );

  always #5 sys_clk = ~sys_clk;

  assign tx_empty = (wr_ptr == rd_ptr);
  assign tx_data  = tx_empty ? 8'h00 : fifo_mem[rd_ptr];

  always @(posedge sys_clk) if (tx_rd_en && !tx_empty) rd_ptr <= rd_ptr + 6'd1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge sys_clk) begin
    if (sys_nrst) begin
      if (cmd_valid) begin
        check("cmd_valid expected", 32'(exp_cmd.size() != 0), 32'd1);
        if (exp_cmd.size() != 0) check("cmd", 32'(cmd), 32'(exp_cmd.pop_front()));
      end
      if (rx_valid) begin
        check("rx_valid expected", 32'(exp_rx.size() != 0), 32'd1);
        if (exp_rx.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      if (frame_end) begin
        check("frame_end expected", 32'(exp_frame.size() != 0), 32'd1);
        if (exp_frame.size() != 0)
          check("frame_err/byte_count", 32'({frame_err, byte_count}), 32'(exp_frame.pop_front()));
      end
      if (tx_rd_en) begin
        pop_cnt++;
        check("pop while fifo empty", 32'(tx_empty), 32'd0);
      end
      while (got_miso.size() != 0) begin
        check("miso byte expected", 32'(exp_miso.size() != 0), 32'd1);
        if (exp_miso.size() != 0) check("miso byte", 32'(got_miso.pop_front()), 32'(exp_miso.pop_front()));
        else void'(got_miso.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fifo_push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      SCK  = 1'b0;
      MOSI = v[7-i];
      #HALF;
      r = {r[6:0], MISO};
      SCK = 1'b1;
      #HALF;
    end
  endtask

  task automatic xfer(input logic [7:0] b);
    logic [7:0] r;
    spi_bits(b, 8, r);
    got_miso.push_back(r);
  endtask

  task automatic nss_low();
    NSS = 1'b0;
    #(2*HALF);
  endtask

  task automatic nss_high();
    #(2*HALF);
    NSS = 1'b1;
    #(3*HALF);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, " MISO"}, 32'(MISO), 32'd0);
    check({tag, " cmd"}, 32'(cmd), 32'd0);
    check({tag, " rx_data"}, 32'(rx_data), 32'd0);
    check({tag, " byte_count"}, 32'(byte_count), 32'd0);
    check({tag, " pulses"}, 32'({cmd_valid, rx_valid, tx_rd_en, frame_end, frame_err}), 32'd0);
    check({tag, " tx_underrun"}, 32'(tx_underrun), 32'd0);
  endtask

  initial begin
    int base;
    logic [7:0] r;
    @(negedge sys_clk);
    #50;
    check_all_zero("reset");
    sys_nrst = 1'b1;
    #100;

    // status readout
    status = 8'h02;
    exp_cmd.push_back(8'h05); exp_miso.push_back(8'h02); exp_frame.push_back({1'b0, 16'd0});
    base = pop_cnt;
    nss_low(); xfer(8'h05); nss_high();
    check("status frame pops", 32'(pop_cnt - base), 32'd0);

    // write frame
    status = 8'h41;
    exp_cmd.push_back(8'h03);
    exp_miso.push_back(8'h41); exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    exp_rx.push_back(8'hA5); exp_rx.push_back(8'h3C);
    exp_frame.push_back({1'b0, 16'd2});
    base = pop_cnt;
    nss_low(); xfer(8'h03); xfer(8'hA5); xfer(8'h3C); nss_high();
    check("write frame pops", 32'(pop_cnt - base), 32'd0);

    // digest read: 16 bytes, reload after the last byte prefetches from an empty FIFO
    status = 8'h02;
    for (int k = 0; k < 16; k++) fifo_push(DIG[k]);
    exp_cmd.push_back(8'h01); exp_miso.push_back(8'h02);
    for (int k = 0; k < 16; k++) begin
      exp_miso.push_back(DIG[k]);
      exp_rx.push_back(8'h00);
    end
    exp_frame.push_back({1'b0, 16'd16});
    base = pop_cnt;
    nss_low(); xfer(8'h01);
    for (int k = 0; k < 15; k++) xfer(8'h00);
    check("digest pops before last byte", 32'(pop_cnt - base), 32'd16);
    check("digest underrun before last byte", 32'(tx_underrun), 32'd0);
    xfer(8'h00); nss_high();
    check("digest pops total", 32'(pop_cnt - base), 32'd16);
    check("digest underrun after prefetch", 32'(tx_underrun), 32'd1);

    // underrun
    fifo_push(8'hDD); fifo_push(8'hF7);
    exp_cmd.push_back(8'h01);
    exp_miso.push_back(8'h02); exp_miso.push_back(8'hDD); exp_miso.push_back(8'hF7);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    for (int k = 0; k < 4; k++) exp_rx.push_back(8'h00);
    exp_frame.push_back({1'b0, 16'd4});
    base = pop_cnt;
    nss_low(); xfer(8'h01);
    for (int k = 0; k < 4; k++) xfer(8'h00);
    nss_high();
    check("underrun pops", 32'(pop_cnt - base), 32'd2);
    check("underrun flag", 32'(tx_underrun), 32'd1);

    // abort mid second data byte
    exp_cmd.push_back(8'h03);
    exp_miso.push_back(8'h02); exp_miso.push_back(8'h00);
    exp_rx.push_back(8'h11);
    exp_frame.push_back({1'b1, 16'd1});
    base = pop_cnt;
    nss_low();
    check("underrun cleared on NSS fall", 32'(tx_underrun), 32'd0);
    xfer(8'h03); xfer(8'h11);
    spi_bits(8'h22, 5, r);
    nss_high();
    check("abort pops", 32'(pop_cnt - base), 32'd0);

    // frame after abort decodes normally
    exp_cmd.push_back(8'h05);
    exp_miso.push_back(8'h02); exp_miso.push_back(8'h00);
    exp_rx.push_back(8'h77);
    exp_frame.push_back({1'b0, 16'd1});
    nss_low(); xfer(8'h05); xfer(8'h77); nss_high();

    // reset during the command byte, release with NSS still low
    nss_low();
    spi_bits(8'h05, 3, r);
    sys_nrst = 1'b0;
    #1;
    check_all_zero("mid-frame reset");
    #49;
    sys_nrst = 1'b1;
    #50;
    spi_bits(8'hFF, 5, r);
    nss_high();
    check("no frame after reset release", 32'(byte_count), 32'd0);

    status = 8'h06;
    exp_cmd.push_back(8'h05); exp_miso.push_back(8'h06); exp_frame.push_back({1'b0, 16'd0});
    nss_low(); xfer(8'h05); nss_high();

    #400;
    check("cmd queue drained", 32'(exp_cmd.size()), 32'd0);
    check("rx queue drained", 32'(exp_rx.size()), 32'd0);
    check("frame queue drained", 32'(exp_frame.size()), 32'd0);
    check("miso queue drained", 32'(exp_miso.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
